count_down_timer: RTL and testbench

//  Countdown core downstream of the minute/second setting stage. Takes the BCD MM:SS preset (M 00-99, S 00-59)
//  and counts it down to 00:00 on one-second ticks. Start/stop, pause, clear and timed alarm are handled by a 4-state FSM.

---
 rtl/count_down_timer_pkg.sv | 16 +
 rtl/count_down_timer_digit.sv | 43 ++++
 rtl/count_down_timer.sv | 179 +++++++++++++++++
 tb/tb_count_down_timer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_down_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// State encoding, BCD digit limits and alarm counter width.
package count_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam int unsigned BCD_MAX_UNIT     = 9;
    localparam int unsigned BCD_MAX_SEC_TENS = 5;
    localparam int unsigned ALARM_CNT_W      = 8;

endpackage

// File: rtl/count_down_timer_digit.sv
// One BCD down-counting digit with clamped load and borrow-out.
// Chained LSD to MSD to form the MM:SS countdown register.
module bcd_down_digit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 9
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             DEC_EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] DIGIT,
    output logic             BORROW
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] digit_q;
    logic [WIDTH-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (LOAD) begin
            digit_d = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
        end else if (DEC_EN) begin
            // Wrap to MAX and let the borrow ripple into the next digit
            digit_d = (digit_q == '0) ? MAX_V : digit_q - ONE_V;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign DIGIT  = digit_q;
    assign BORROW = (digit_q == '0) & DEC_EN;

endmodule

// File: rtl/count_down_timer.sv
// MM:SS countdown core: preset load, BCD countdown, pause and timed alarm.
// Drives the display mux digits and the buzzer/LED flags.
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int unsigned ALARM_SECONDS = 10
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [3:0] SET_M_HI,
    input  logic [3:0] SET_M_LO,
    input  logic [2:0] SET_S_HI,
    input  logic [3:0] SET_S_LO,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       ONE_SEC_PULSE,
    input  logic       HALF_SEC_PULSE,
    output logic [3:0] DISP_M_HI,
    output logic [3:0] DISP_M_LO,
    output logic [2:0] DISP_S_HI,
    output logic [3:0] DISP_S_LO,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       ALARM_BLINK
);

    localparam logic [ALARM_CNT_W-1:0] ALARM_LAST =
        ALARM_CNT_W'(ALARM_SECONDS);

    state_e state_q, state_d;

    logic [ALARM_CNT_W-1:0] cnt_q, cnt_d;
    logic                   blink_q, blink_d;
    logic                   running_q, alarm_q;

    logic [3:0] m_hi, m_lo, s_lo;
    logic [2:0] s_hi;
    logic       s_lo_bw, s_hi_bw, m_lo_bw, m_hi_bw;

    logic is_idle, at_zero, at_one;
    logic go, load, dec;

    assign is_idle = (state_q == ST_IDLE);
    assign at_zero = (m_hi == 4'd0) & (m_lo == 4'd0)
                   & (s_hi == 3'd0) & (s_lo == 4'd0);
    assign at_one  = (m_hi == 4'd0) & (m_lo == 4'd0)
                   & (s_hi == 3'd0) & (s_lo == 4'd1);

    // Freeze the preset on the start edge so RUN never begins at 00:00
    assign go   = is_idle & START_STOP & ~CLEAR & ~at_zero;
    assign load = is_idle & ~go;
    assign dec  = (state_q == ST_RUN) & ONE_SEC_PULSE
                & ~CLEAR & ~at_zero;

    bcd_down_digit #(
        .WIDTH (4),
        .MAX   (BCD_MAX_UNIT)
    ) u_s_lo (
        .CLK      (CLK),
        .RES      (RES),
        .DEC_EN   (dec),
        .LOAD     (load),
        .LOAD_VAL (SET_S_LO),
        .DIGIT    (s_lo),
        .BORROW   (s_lo_bw)
    );

    bcd_down_digit #(
        .WIDTH (3),
        .MAX   (BCD_MAX_SEC_TENS)
    ) u_s_hi (
        .CLK      (CLK),
        .RES      (RES),
        .DEC_EN   (s_lo_bw),
        .LOAD     (load),
        .LOAD_VAL (SET_S_HI),
        .DIGIT    (s_hi),
        .BORROW   (s_hi_bw)
    );

    bcd_down_digit #(
        .WIDTH (4),
        .MAX   (BCD_MAX_UNIT)
    ) u_m_lo (
        .CLK      (CLK),
        .RES      (RES),
        .DEC_EN   (s_hi_bw),
        .LOAD     (load),
        .LOAD_VAL (SET_M_LO),
        .DIGIT    (m_lo),
        .BORROW   (m_lo_bw)
    );

    bcd_down_digit #(
        .WIDTH (4),
        .MAX   (BCD_MAX_UNIT)
    ) u_m_hi (
        .CLK      (CLK),
        .RES      (RES),
        .DEC_EN   (m_lo_bw),
        .LOAD     (load),
        .LOAD_VAL (SET_M_HI),
        .DIGIT    (m_hi),
        .BORROW   (m_hi_bw)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A borrow out of the top digit would mean underflow
                if (CLEAR) begin
                    state_d = ST_IDLE;
                end else if (dec & (at_one | m_hi_bw)) begin
                    state_d = ST_ALARM;
                end else if (START_STOP) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (CLEAR) begin
                    state_d = ST_IDLE;
                end else if (START_STOP) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (CLEAR | START_STOP) begin
                    state_d = ST_IDLE;
                end else if (ONE_SEC_PULSE &
                             (cnt_q + 8'd1 == ALARM_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d   = '0;
        blink_d = 1'b0;
        if ((state_q == ST_ALARM) & (state_d == ST_ALARM)) begin
            cnt_d   = cnt_q + {7'd0, ONE_SEC_PULSE};
            blink_d = blink_q ^ HALF_SEC_PULSE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    assign DISP_M_HI   = m_hi;
    assign DISP_M_LO   = m_lo;
    assign DISP_S_HI   = s_hi;
    assign DISP_S_LO   = s_lo;
    assign RUNNING     = running_q;
    assign ALARM       = alarm_q;
    assign ALARM_BLINK = blink_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Scenario and randomized bench for count_down_timer.
// Reference model tracks remaining time as a plain seconds count.
module tb_count_down_timer;

    localparam int AS = 10;

    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic [3:0] SET_M_HI = '0;
    logic [3:0] SET_M_LO = '0;
    logic [2:0] SET_S_HI = '0;
    logic [3:0] SET_S_LO = '0;
    logic       START_STOP = 1'b0;
    logic       CLEAR = 1'b0;
    logic       ONE_SEC_PULSE = 1'b0;
    logic       HALF_SEC_PULSE = 1'b0;
    logic [3:0] DISP_M_HI;
    logic [3:0] DISP_M_LO;
    logic [2:0] DISP_S_HI;
    logic [3:0] DISP_S_LO;
    logic       RUNNING;
    logic       ALARM;
    logic       ALARM_BLINK;

    logic [14:0] dut_disp;
    assign dut_disp = {DISP_M_HI, DISP_M_LO, DISP_S_HI, DISP_S_LO};

    count_down_timer #(
        .ALARM_SECONDS (AS)
    ) dut (
        .CLK            (CLK),
        .RES            (RES),
        .SET_M_HI       (SET_M_HI),
        .SET_M_LO       (SET_M_LO),
        .SET_S_HI       (SET_S_HI),
        .SET_S_LO       (SET_S_LO),
        .START_STOP     (START_STOP),
        .CLEAR          (CLEAR),
        .ONE_SEC_PULSE  (ONE_SEC_PULSE),
        .HALF_SEC_PULSE (HALF_SEC_PULSE),
        .DISP_M_HI      (DISP_M_HI),
        .DISP_M_LO      (DISP_M_LO),
        .DISP_S_HI      (DISP_S_HI),
        .DISP_S_LO      (DISP_S_LO),
        .RUNNING        (RUNNING),
        .ALARM          (ALARM),
        .ALARM_BLINK    (ALARM_BLINK)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 counting, 2 paused, 3 alarming
    int mmode  = 0;
    int mtot   = 0;
    int mcnt   = 0;
    bit mblink = 1'b0;

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int set_total();
        int m;
        int s;
        m = clampi(int'(SET_M_HI), 9) * 10 + clampi(int'(SET_M_LO), 9);
        s = clampi(int'(SET_S_HI), 5) * 10 + clampi(int'(SET_S_LO), 9);
        return m * 60 + s;
    endfunction

    function automatic logic [14:0] pack(int mh, int ml, int sh, int sl);
        return {4'(mh), 4'(ml), 3'(sh), 4'(sl)};
    endfunction

    function automatic logic [14:0] model_disp();
        int m;
        int s;
        m = mtot / 60;
        s = mtot % 60;
        return pack(m / 10, m % 10, s / 10, s % 10);
    endfunction

    task automatic model_update();
        int st;
        st = set_total();
        if (RES) begin
            mmode = 0; mtot = 0; mcnt = 0; mblink = 0;
        end else if (CLEAR) begin
            if (mmode == 0) mtot = st;
            mmode = 0; mcnt = 0; mblink = 0;
        end else begin
            case (mmode)
                0: begin
                    if (START_STOP && mtot != 0) mmode = 1;
                    else mtot = st;
                end
                1: begin
                    if (ONE_SEC_PULSE) begin
                        mtot = mtot - 1;
                        if (mtot == 0) begin
                            mmode = 3; mcnt = 0; mblink = 0;
                        end else if (START_STOP) begin
                            mmode = 2;
                        end
                    end else if (START_STOP) begin
                        mmode = 2;
                    end
                end
                2: begin
                    if (START_STOP) mmode = 1;
                end
                default: begin
                    if (START_STOP) begin
                        mmode = 0; mcnt = 0; mblink = 0;
                    end else begin
                        if (ONE_SEC_PULSE) mcnt = mcnt + 1;
                        if (mcnt == AS) begin
                            mmode = 0; mcnt = 0; mblink = 0;
                        end else if (HALF_SEC_PULSE) begin
                            mblink = !mblink;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        START_STOP     = 1'b0;
        CLEAR          = 1'b0;
        ONE_SEC_PULSE  = 1'b0;
        HALF_SEC_PULSE = 1'b0;
    endtask

    task automatic preset(int mh, int ml, int sh, int sl);
        SET_M_HI = 4'(mh);
        SET_M_LO = 4'(ml);
        SET_S_HI = 3'(sh);
        SET_S_LO = 4'(sl);
        step();
    endtask

    task automatic tick();
        ONE_SEC_PULSE  = 1'b1;
        HALF_SEC_PULSE = 1'b1;
        step();
    endtask

    task automatic abort();
        CLEAR = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        SET_M_HI = 4'd3; SET_M_LO = 4'd4; SET_S_HI = 3'd2; SET_S_LO = 4'd1;
        RES = 1'b1;
        step();
        RES = 1'b0;
        checks++;
        if (dut_disp !== 15'd0 || {RUNNING, ALARM, ALARM_BLINK} !== 3'b000) begin
            failures++;
            $display("FAIL reset: disp=%h flags=%b want 0000 000", dut_disp,
                     {RUNNING, ALARM, ALARM_BLINK});
        end
        step();
        checks++;
        if (dut_disp !== pack(3, 4, 2, 1)) begin
            failures++;
            $display("FAIL idle_load: disp=%h want %h", dut_disp, pack(3, 4, 2, 1));
        end
    endtask

    task automatic test_countdown();
        preset(0, 1, 0, 5);
        START_STOP = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (RUNNING !== 1'b1) begin
                failures++;
                $display("FAIL run_flag: RUNNING=%b want 1 at tick %0d", RUNNING, i);
            end
            tick();
        end
        checks++;
        if (dut_disp !== pack(0, 1, 0, 0)) begin
            failures++;
            $display("FAIL count_0100: disp=%h want %h", dut_disp, pack(0, 1, 0, 0));
        end
        tick();
        checks++;
        if (dut_disp !== pack(0, 0, 5, 9) || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL borrow_0059: disp=%h run=%b want %h 1", dut_disp, RUNNING,
                     pack(0, 0, 5, 9));
        end
        abort();
    endtask

    task automatic test_alarm_timeout();
        preset(0, 0, 0, 2);
        START_STOP = 1'b1;
        step();
        tick();
        tick();
        checks++;
        if (ALARM !== 1'b1 || RUNNING !== 1'b0 || dut_disp !== 15'd0) begin
            failures++;
            $display("FAIL alarm_entry: alarm=%b run=%b disp=%h want 1 0 0000",
                     ALARM, RUNNING, dut_disp);
        end
        for (int i = 0; i < AS - 1; i++) tick();
        checks++;
        if (ALARM !== 1'b1 || dut_disp !== 15'd0) begin
            failures++;
            $display("FAIL alarm_hold: alarm=%b disp=%h want 1 0000", ALARM, dut_disp);
        end
        tick();
        checks++;
        if (ALARM !== 1'b0 || ALARM_BLINK !== 1'b0) begin
            failures++;
            $display("FAIL alarm_timeout: alarm=%b blink=%b want 0 0", ALARM, ALARM_BLINK);
        end
        step();
        checks++;
        if (dut_disp !== pack(0, 0, 0, 2)) begin
            failures++;
            $display("FAIL alarm_reload: disp=%h want %h", dut_disp, pack(0, 0, 0, 2));
        end
    endtask

    task automatic test_zero_and_clamp();
        preset(0, 0, 0, 0);
        START_STOP = 1'b1;
        step();
        step();
        checks++;
        if (RUNNING !== 1'b0) begin
            failures++;
            $display("FAIL zero_start: RUNNING=%b want 0", RUNNING);
        end
        preset(9, 9, 5, 9);
        checks++;
        if (dut_disp !== pack(9, 9, 5, 9)) begin
            failures++;
            $display("FAIL load_9959: disp=%h want %h", dut_disp, pack(9, 9, 5, 9));
        end
        preset(1, 12, 7, 15);
        checks++;
        if (dut_disp !== pack(1, 9, 5, 9)) begin
            failures++;
            $display("FAIL clamp: disp=%h want %h", dut_disp, pack(1, 9, 5, 9));
        end
    endtask

    task automatic test_pause();
        preset(0, 0, 1, 0);
        START_STOP = 1'b1;
        step();
        START_STOP = 1'b1;
        tick();
        checks++;
        if (dut_disp !== pack(0, 0, 0, 9) || RUNNING !== 1'b0) begin
            failures++;
            $display("FAIL pause_coinc: disp=%h run=%b want %h 0", dut_disp, RUNNING,
                     pack(0, 0, 0, 9));
        end
        SET_S_LO = 4'd4;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (dut_disp !== pack(0, 0, 0, 9)) begin
            failures++;
            $display("FAIL pause_frozen: disp=%h want %h", dut_disp, pack(0, 0, 0, 9));
        end
        START_STOP = 1'b1;
        step();
        checks++;
        if (RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL resume: RUNNING=%b want 1", RUNNING);
        end
        tick();
        checks++;
        if (dut_disp !== pack(0, 0, 0, 8)) begin
            failures++;
            $display("FAIL resume_tick: disp=%h want %h", dut_disp, pack(0, 0, 0, 8));
        end
        abort();
    endtask

    task automatic test_alarm_blink();
        preset(0, 0, 0, 1);
        START_STOP = 1'b1;
        step();
        START_STOP = 1'b1;
        tick();
        checks++;
        if ({RUNNING, ALARM, ALARM_BLINK} !== 3'b010) begin
            failures++;
            $display("FAIL coinc_alarm: flags=%b want 010", {RUNNING, ALARM, ALARM_BLINK});
        end
        HALF_SEC_PULSE = 1'b1;
        step();
        checks++;
        if (ALARM_BLINK !== 1'b1) begin
            failures++;
            $display("FAIL blink_on: blink=%b want 1", ALARM_BLINK);
        end
        HALF_SEC_PULSE = 1'b1;
        step();
        checks++;
        if (ALARM_BLINK !== 1'b0) begin
            failures++;
            $display("FAIL blink_off: blink=%b want 0", ALARM_BLINK);
        end
        HALF_SEC_PULSE = 1'b1;
        CLEAR = 1'b1;
        step();
        checks++;
        if ({ALARM, ALARM_BLINK} !== 2'b00) begin
            failures++;
            $display("FAIL clear_alarm: flags=%b want 00", {ALARM, ALARM_BLINK});
        end
        step();
        checks++;
        if (dut_disp !== pack(0, 0, 0, 1)) begin
            failures++;
            $display("FAIL clear_reload: disp=%h want %h", dut_disp, pack(0, 0, 0, 1));
        end
    endtask

    task automatic test_reset_midrun();
        preset(1, 2, 3, 4);
        START_STOP = 1'b1;
        step();
        tick();
        RES = 1'b1;
        step();
        RES = 1'b0;
        checks++;
        if (dut_disp !== 15'd0 || {RUNNING, ALARM, ALARM_BLINK} !== 3'b000) begin
            failures++;
            $display("FAIL reset_midrun: disp=%h flags=%b want 0000 000", dut_disp,
                     {RUNNING, ALARM, ALARM_BLINK});
        end
        preset(0, 5, 4, 3);
        checks++;
        if (dut_disp !== pack(0, 5, 4, 3)) begin
            failures++;
            $display("FAIL post_reset_load: disp=%h want %h", dut_disp, pack(0, 5, 4, 3));
        end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        RES = 1'b1;
        step();
        RES = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            ONE_SEC_PULSE  = (k % 8 == 7);
            HALF_SEC_PULSE = (k % 4 == 3);
            START_STOP     = ($urandom_range(0, 9) == 0);
            CLEAR          = ($urandom_range(0, 79) == 0);
            RES            = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    SET_M_HI = 4'($urandom_range(0, 15));
                    SET_M_LO = 4'($urandom_range(0, 15));
                    SET_S_HI = 3'($urandom_range(0, 7));
                    SET_S_LO = 4'($urandom_range(0, 15));
                end else begin
                    SET_M_HI = 4'd0;
                    SET_M_LO = 4'd0;
                    SET_S_HI = 3'($urandom_range(0, 1));
                    SET_S_LO = 4'($urandom_range(0, 12));
                end
            end
            step();
            RES = 1'b0;
            checks++;
            if (dut_disp !== model_disp()) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_disp: cyc=%0d disp=%h want %h", k, dut_disp,
                             model_disp());
                end
            end
            checks++;
            if ({RUNNING, ALARM, ALARM_BLINK} !==
                {mmode == 1, mmode == 3, mblink}) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_flags: cyc=%0d flags=%b want %b", k,
                             {RUNNING, ALARM, ALARM_BLINK},
                             {mmode == 1, mmode == 3, mblink});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_alarm_timeout();
        test_zero_and_clamp();
        test_pause();
        test_alarm_blink();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
